nvdla_sdp_core_gather: RTL and testbench

- Narrow-to-wide beat gatherer for the SDP datapath; the inverse of the SDP wide-to-narrow segment splitter.
- Collects RATIO consecutive IW-bit beats into one OW-bit word; beat k lands in segment k (LSB first).
- Supports early termination via inp_last; unwritten segments are zero-filled and flagged invalid in out_mask.
- Sits between narrow-width SDP sub-units and wide write/DMA paths. Valid/ready on both sides; sustains 1 input beat per cycle.

---
 rtl/nvdla_sdp_core_gather.sv | 83 ++++++++
 tb/tb_nvdla_sdp_core_gather.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_sdp_core_gather.sv
// Narrow-to-wide beat gatherer: packs RATIO consecutive IW-bit beats into one
// OW-bit word, LSB segment first, with early termination via inp_last.
module nvdla_sdp_core_gather #(
   parameter int IW    = 128,
   parameter int OW    = 512,
   parameter int RATIO = OW / IW
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             inp_pvld,
   output logic             inp_prdy,
   input  logic [IW-1:0]    inp_data,
   input  logic             inp_last,
   output logic             out_pvld,
   input  logic             out_prdy,
   output logic [OW-1:0]    out_data,
   output logic [RATIO-1:0] out_mask
);

   if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8 || RATIO == 16) || (OW != IW * RATIO)) begin : g_cfg_err
      $error("nvdla_sdp_core_gather: illegal RATIO/IW/OW combination");
   end

   logic [3:0]       gather_cnt;
   logic [OW-1:0]    acc_data;
   logic [RATIO-1:0] acc_mask;
   logic [OW-1:0]    merged_data;
   logic [RATIO-1:0] merged_mask;
   logic             inp_acc;
   logic             out_acc;
   logic             word_done;

   // Handshake: a transfer happens on a side when pvld and prdy are both high
   // at the clock edge. inp_prdy depends only on registered out_pvld and the
   // downstream out_prdy, so a stalled output word blocks every input beat.
   assign inp_prdy  = !out_pvld | out_prdy;
   assign inp_acc   = inp_pvld & inp_prdy;
   assign out_acc   = out_pvld & out_prdy;
   assign word_done = (gather_cnt == 4'(RATIO - 1)) | inp_last;

   // Accumulator with the incoming beat dropped into the current segment.
   always_comb begin
      merged_data = acc_data;
      merged_mask = acc_mask;
      for (int k = 0; k < RATIO; k++) begin
         if (gather_cnt == 4'(k)) begin
            merged_data[k*IW +: IW] = inp_data;
            merged_mask[k]          = 1'b1;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         gather_cnt <= 4'd0;
         acc_data   <= '0;
         acc_mask   <= '0;
         out_pvld   <= 1'b0;
         out_data   <= '0;
         out_mask   <= '0;
      end else begin
         if (out_acc) begin
            out_pvld <= 1'b0;
         end
         if (inp_acc) begin
            if (word_done) begin
               // A completing beat overrides the drain above: no bubble.
               out_data   <= merged_data;
               out_mask   <= merged_mask;
               out_pvld   <= 1'b1;
               acc_data   <= '0;
               acc_mask   <= '0;
               gather_cnt <= 4'd0;
            end else begin
               acc_data   <= merged_data;
               acc_mask   <= merged_mask;
               gather_cnt <= gather_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nvdla_sdp_core_gather.sv
// Self-checking bench for nvdla_sdp_core_gather: five builds (RATIO 4/8/2/1/16)
// share one stimulus bus; a reference model feeds an expected-word queue.
module tb_nvdla_sdp_core_gather;

   localparam int W = 528;  // {mask[15:0], data[511:0]}

   logic         nvdla_core_clk;
   logic         nvdla_core_rstn;
   logic         inp_pvld;
   logic [127:0] inp_data;
   logic         inp_last;
   logic         out_prdy;
   int           sel;
   int           cyc;

   int pass_cnt;
   int fail_cnt;
   int total_cnt;
   int beats_seen;
   int words_seen;

   logic [W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial nvdla_core_clk = 1'b0;
   always #5 nvdla_core_clk = ~nvdla_core_clk;
   initial cyc = 0;
   always @(posedge nvdla_core_clk) cyc++;

   // ---------------- DUT builds ----------------
   logic         prdy0, pv0;  logic [511:0] od0;  logic [3:0]  mk0;
   logic         prdy1, pv1;  logic [127:0] od1;  logic [7:0]  mk1;
   logic         prdy2, pv2;  logic [31:0]  od2;  logic [1:0]  mk2;
   logic         prdy3, pv3;  logic [15:0]  od3;  logic [0:0]  mk3;
   logic         prdy4, pv4;  logic [127:0] od4;  logic [15:0] mk4;

   nvdla_sdp_core_gather #(.IW(128), .OW(512), .RATIO(4)) u_r4 (
      .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
      .inp_pvld(inp_pvld && sel == 0), .inp_prdy(prdy0), .inp_data(inp_data),
      .inp_last(inp_last), .out_pvld(pv0), .out_prdy(out_prdy),
      .out_data(od0), .out_mask(mk0));
   nvdla_sdp_core_gather #(.IW(16), .OW(128), .RATIO(8)) u_r8 (
      .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
      .inp_pvld(inp_pvld && sel == 1), .inp_prdy(prdy1), .inp_data(inp_data[15:0]),
      .inp_last(inp_last), .out_pvld(pv1), .out_prdy(out_prdy),
      .out_data(od1), .out_mask(mk1));
   nvdla_sdp_core_gather #(.IW(16), .OW(32), .RATIO(2)) u_r2 (
      .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
      .inp_pvld(inp_pvld && sel == 2), .inp_prdy(prdy2), .inp_data(inp_data[15:0]),
      .inp_last(inp_last), .out_pvld(pv2), .out_prdy(out_prdy),
      .out_data(od2), .out_mask(mk2));
   nvdla_sdp_core_gather #(.IW(16), .OW(16), .RATIO(1)) u_r1 (
      .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
      .inp_pvld(inp_pvld && sel == 3), .inp_prdy(prdy3), .inp_data(inp_data[15:0]),
      .inp_last(inp_last), .out_pvld(pv3), .out_prdy(out_prdy),
      .out_data(od3), .out_mask(mk3));
   nvdla_sdp_core_gather #(.IW(8), .OW(128), .RATIO(16)) u_r16 (
      .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
      .inp_pvld(inp_pvld && sel == 4), .inp_prdy(prdy4), .inp_data(inp_data[7:0]),
      .inp_last(inp_last), .out_pvld(pv4), .out_prdy(out_prdy),
      .out_data(od4), .out_mask(mk4));

   logic         prdy_m;
   logic         pvld_m;
   logic [511:0] data_m;
   logic [15:0]  mask_m;

   always_comb begin
      prdy_m = prdy0; pvld_m = pv0; data_m = od0; mask_m = 16'(mk0);
      case (sel)
         1: begin prdy_m = prdy1; pvld_m = pv1; data_m = 512'(od1); mask_m = 16'(mk1); end
         2: begin prdy_m = prdy2; pvld_m = pv2; data_m = 512'(od2); mask_m = 16'(mk2); end
         3: begin prdy_m = prdy3; pvld_m = pv3; data_m = 512'(od3); mask_m = 16'(mk3); end
         4: begin prdy_m = prdy4; pvld_m = pv4; data_m = 512'(od4); mask_m = mk4;        end
         default: ;
      endcase
   end

   // ---------------- check helper ----------------
   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   int           ratio_t[5] = '{4, 8, 2, 1, 16};
   int           iw_t[5]    = '{128, 16, 16, 16, 8};
   int           m_cnt;
   logic [511:0] m_word;
   logic [15:0]  m_mask;

   always @(negedge nvdla_core_clk) begin
      logic [W-1:0]   e;
      logic [127:0]   d;
      if (!nvdla_core_rstn) begin
         exp_q.delete();
         m_cnt  = 0;
         m_word = '0;
         m_mask = '0;
      end else begin
         if (pvld_m && out_prdy) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_word", 512'(1), 512'(0));
            end else begin
               e = exp_q.pop_front();
               check("sb_data", data_m, e[511:0]);
               check("sb_mask", 512'(mask_m), 512'(e[527:512]));
               words_seen++;
            end
         end
         if (inp_pvld && prdy_m) begin
            beats_seen++;
            d = inp_data & ((128'(1) << iw_t[sel]) - 128'(1));
            if (iw_t[sel] == 128) d = inp_data;
            m_word = m_word | (512'(d) << (m_cnt * iw_t[sel]));
            m_mask[m_cnt] = 1'b1;
            if (m_cnt == ratio_t[sel] - 1 || (inp_last && ratio_t[sel] != 1)) begin
               exp_q.push_back({m_mask, m_word});
               m_cnt  = 0;
               m_word = '0;
               m_mask = '0;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      inp_pvld = 1'b0;
      repeat (n) @(posedge nvdla_core_clk);
      #1;
   endtask

   // Present one beat and hold it until accepted; returns at edge+1.
   task automatic send(input logic [127:0] d, input logic l);
      logic got;
      got      = 1'b0;
      inp_pvld = 1'b1;
      inp_data = d;
      inp_last = l;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge nvdla_core_clk);
         got = prdy_m;
         @(posedge nvdla_core_clk);
         #1;
      end
      inp_pvld = 1'b0;
      if (!got) check("send_timeout", 512'(got), 512'(1));
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [127:0] a[4];
      logic [127:0] b[2];
      logic [127:0] c0, f0, x;
      logic [15:0]  d_stale, d0, d1;
      logic [511:0] snap;
      int           t0;
      int           n;

      pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
      beats_seen = 0; words_seen = 0;
      nvdla_core_rstn = 1'b0;
      inp_pvld = 1'b0; inp_data = '0; inp_last = 1'b0;
      out_prdy = 1'b1; sel = 0;
      repeat (3) @(posedge nvdla_core_clk);
      @(negedge nvdla_core_clk);
      check("rst_out_pvld", 512'(pvld_m), 512'(0));
      check("rst_out_mask", 512'(mask_m), 512'(0));
      check("rst_out_data", data_m, 512'(0));
      check("rst_inp_prdy", 512'(prdy_m), 512'(1));
      @(posedge nvdla_core_clk); #1;
      nvdla_core_rstn = 1'b1;

      // full RATIO=4 word
      for (int i = 0; i < 4; i++) a[i] = rnd128();
      for (int i = 0; i < 4; i++) send(a[i], 1'b0);
      check("full_pvld", 512'(pvld_m), 512'(1));
      check("full_data", data_m, {a[3], a[2], a[1], a[0]});
      check("full_mask", 512'(mask_m), 512'(4'hf));

      // continuous stream: 8 beats take exactly 8 cycles
      t0 = cyc;
      for (int i = 0; i < 8; i++) send(rnd128(), 1'b0);
      check("stream_cycles", 512'(cyc - t0), 512'(8));
      idle(2);

      // early termination and restart at segment 0
      b[0] = rnd128(); b[1] = rnd128();
      send(b[0], 1'b0);
      send(b[1], 1'b1);
      check("early_data", data_m, {256'b0, b[1], b[0]});
      check("early_mask", 512'(mask_m), 512'(4'h3));
      c0 = rnd128();
      send(c0, 1'b0);
      for (int i = 0; i < 3; i++) send(rnd128(), 1'b0);
      check("restart_seg0", 512'(data_m[127:0]), 512'(c0));
      idle(2);

      // backpressure: stalled word blocks input, stays stable
      out_prdy = 1'b0;
      for (int i = 0; i < 4; i++) send(rnd128(), i == 3);
      check("bp_pvld", 512'(pvld_m), 512'(1));
      @(negedge nvdla_core_clk);
      check("bp_inp_prdy", 512'(prdy_m), 512'(0));
      snap = data_m;
      for (int i = 0; i < 5; i++) begin
         @(negedge nvdla_core_clk);
         check("bp_stable", data_m, snap);
      end
      @(posedge nvdla_core_clk); #1;
      out_prdy = 1'b1;
      f0 = rnd128();
      inp_pvld = 1'b1; inp_data = f0; inp_last = 1'b1;
      @(negedge nvdla_core_clk);
      check("bp_release_prdy", 512'(prdy_m), 512'(1));
      @(posedge nvdla_core_clk); #1;
      inp_pvld = 1'b0;
      check("b2b_pvld", 512'(pvld_m), 512'(1));
      check("b2b_data", data_m, {384'b0, f0});
      idle(3);

      // RATIO=8 random traffic
      sel = 1;
      t0 = beats_seen;
      n = 0;
      while (beats_seen - t0 < 1000 && n < 20000) begin
         inp_pvld = 1'($urandom_range(0, 1));
         inp_data = rnd128();
         inp_last = ($urandom_range(0, 5) == 0);
         out_prdy = 1'($urandom_range(0, 1));
         @(posedge nvdla_core_clk); #1;
         n++;
      end
      if (n >= 20000) check("rnd_budget", 512'(beats_seen - t0), 512'(1000));
      out_prdy = 1'b1;
      send(rnd128(), 1'b1);
      idle(3);
      check("rnd_drained", 512'(exp_q.size()), 512'(0));

      // RATIO=2 reset mid-word discards the stale beat
      sel = 2;
      d_stale = 16'($urandom); d0 = 16'($urandom); d1 = 16'($urandom);
      send(128'(d_stale), 1'b0);
      idle(1);
      nvdla_core_rstn = 1'b0;
      @(negedge nvdla_core_clk);
      check("mid_rst_pvld", 512'(pvld_m), 512'(0));
      @(posedge nvdla_core_clk); #1;
      nvdla_core_rstn = 1'b1;
      @(negedge nvdla_core_clk);
      check("post_rst_mask", 512'(mask_m), 512'(0));
      @(posedge nvdla_core_clk); #1;
      send(128'(d0), 1'b0);
      send(128'(d1), 1'b0);
      check("r2_data", data_m, 512'({d1, d0}));
      check("r2_mask", 512'(mask_m), 512'(2'b11));
      idle(2);

      // RATIO=1 pass-through
      sel = 3;
      for (int i = 0; i < 3; i++) begin
         x = 128'(16'($urandom));
         send(x, 1'($urandom_range(0, 1)));
         check("r1_pvld", 512'(pvld_m), 512'(1));
         check("r1_data", data_m, 512'(x));
         check("r1_mask", 512'(mask_m), 512'(1));
      end
      idle(2);

      // RATIO=16 full word and single-beat word
      sel = 4;
      for (int i = 0; i < 16; i++) send(128'(8'($urandom)), 1'b0);
      check("r16_full_mask", 512'(mask_m), 512'(16'hffff));
      idle(2);
      x = 128'(8'($urandom));
      send(x, 1'b1);
      check("r16_last0_mask", 512'(mask_m), 512'(16'h0001));
      check("r16_last0_data", data_m, 512'(x));
      idle(3);

      check("final_queue_empty", 512'(exp_q.size()), 512'(0));
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
